// File: rtl/prot_accum_pkg.sv
// Shared constants and types for the protected accumulator / pass-through block.
// The optional saturating accumulator is enabled by defining PROT_ACCUM_SAT_EN.
package prot_accum_pkg;

    localparam int ACC_W_DEF    = 32;
    localparam int MAX_PASS_DLY = 4;

    localparam int LANE1_W   = 1;
    localparam int LANE2_W   = 2;
    localparam int LANE8_W   = 8;
    localparam int LANE33_W  = 33;
    localparam int LANE64_W  = 64;
    localparam int LANE65_W  = 65;
    localparam int LANE129_W = 129;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_t;

endpackage

// File: rtl/prot_pass_pipe.sv
// Fixed-latency delay line for one pass-through lane; DLY = 0 is a plain wire.
module prot_pass_pipe #(
    parameter int WIDTH = 1,
    parameter int DLY   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DLY == 0) begin : g_wire
            logic unused_clk_s;
            assign unused_clk_s = clk ^ rst_n;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_r [DLY];

            // Shift register: stage 0 samples the input, the last stage drives the output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DLY; i++) begin
                        stage_r[i] <= '0;
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DLY; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/prot_accum_secret.sv
// Protected "secret" block: 32-bit accumulator with bypass mux plus delayed lanes.
// Define PROT_ACCUM_SAT_EN for a saturating accumulator with a sticky sat_flag port.
module prot_accum_secret
    import prot_accum_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int PASS_DLY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef PROT_ACCUM_SAT_EN
    output logic                 sat_flag,
`endif
    input  logic [ACC_W-1:0]     accum_in,
    output logic [ACC_W-1:0]     accum_out,
    input  logic                 accum_bypass,
    output logic [ACC_W-1:0]     accum_bypass_out,
    output logic                 acc_valid,
    input  logic [LANE1_W-1:0]   s1_in,
    output logic [LANE1_W-1:0]   s1_out,
    input  logic [LANE2_W-1:0]   s2_in,
    output logic [LANE2_W-1:0]   s2_out,
    input  logic [LANE8_W-1:0]   s8_in,
    output logic [LANE8_W-1:0]   s8_out,
    input  logic [LANE33_W-1:0]  s33_in,
    output logic [LANE33_W-1:0]  s33_out,
    input  logic [LANE64_W-1:0]  s64_in,
    output logic [LANE64_W-1:0]  s64_out,
    input  logic [LANE65_W-1:0]  s65_in,
    output logic [LANE65_W-1:0]  s65_out,
    input  logic [LANE129_W-1:0] s129_in,
    output logic [LANE129_W-1:0] s129_out,
    output logic                 pass_valid
);

    if (PASS_DLY < 0 || PASS_DLY > MAX_PASS_DLY) begin : g_bad_dly
        $fatal(1, "prot_accum_secret: PASS_DLY out of range 0..4");
    end

    localparam fill_state_t RESET_STATE = (PASS_DLY == 0) ? RUN : FILL;
    localparam logic [2:0]  LAST_CNT    = (PASS_DLY == 0) ? 3'd0 : 3'(PASS_DLY - 1);

    logic [ACC_W-1:0] acc_r;
    logic             acc_valid_r;
    logic [ACC_W-1:0] bypass_s;
    fill_state_t      state_r;
    logic [2:0]       cnt_r;
    logic             pass_valid_r;

`ifdef PROT_ACCUM_SAT_EN
    logic             sat_r;
    logic [ACC_W:0]   sum_s;
    assign sum_s    = {1'b0, acc_r} + {1'b0, accum_in};
    assign sat_flag = sat_r;
`endif

    // Accumulator: adds accum_in every edge, wrapping or clamping on carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= '0;
            acc_valid_r <= 1'b0;
`ifdef PROT_ACCUM_SAT_EN
            sat_r       <= 1'b0;
`endif
        end else begin
`ifdef PROT_ACCUM_SAT_EN
            if (sum_s[ACC_W]) begin
                acc_r <= '1;
                sat_r <= 1'b1;
            end else begin
                acc_r <= sum_s[ACC_W-1:0];
                sat_r <= sat_r;
            end
`else
            acc_r <= acc_r + accum_in;
`endif
            acc_valid_r <= 1'b1;
        end
    end

    // Bypass mux; an unknown select falls to the else arm and shows the accumulator.
    always_comb begin
        bypass_s = acc_r;
        if (accum_bypass == 1'b1) begin
            bypass_s = accum_in;
        end else begin
            bypass_s = acc_r;
        end
    end

    // Fill tracker: counts edges until the lanes hold PASS_DLY real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RESET_STATE;
            cnt_r        <= 3'd0;
            pass_valid_r <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (cnt_r == LAST_CNT) begin
                        state_r      <= RUN;
                        cnt_r        <= cnt_r;
                        pass_valid_r <= 1'b1;
                    end else begin
                        state_r      <= FILL;
                        cnt_r        <= cnt_r + 3'd1;
                        pass_valid_r <= 1'b0;
                    end
                end
                RUN: begin
                    state_r      <= RUN;
                    cnt_r        <= cnt_r;
                    pass_valid_r <= 1'b1;
                end
                default: begin
                    state_r      <= FILL;
                    cnt_r        <= 3'd0;
                    pass_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign accum_out        = acc_r;
    assign acc_valid        = acc_valid_r;
    assign accum_bypass_out = bypass_s;
    assign pass_valid       = pass_valid_r;

    prot_pass_pipe #(.WIDTH(LANE1_W), .DLY(PASS_DLY)) u_s1 (
        .clk(clk), .rst_n(rst_n), .din(s1_in), .dout(s1_out));
    prot_pass_pipe #(.WIDTH(LANE2_W), .DLY(PASS_DLY)) u_s2 (
        .clk(clk), .rst_n(rst_n), .din(s2_in), .dout(s2_out));
    prot_pass_pipe #(.WIDTH(LANE8_W), .DLY(PASS_DLY)) u_s8 (
        .clk(clk), .rst_n(rst_n), .din(s8_in), .dout(s8_out));
    prot_pass_pipe #(.WIDTH(LANE33_W), .DLY(PASS_DLY)) u_s33 (
        .clk(clk), .rst_n(rst_n), .din(s33_in), .dout(s33_out));
    prot_pass_pipe #(.WIDTH(LANE64_W), .DLY(PASS_DLY)) u_s64 (
        .clk(clk), .rst_n(rst_n), .din(s64_in), .dout(s64_out));
    prot_pass_pipe #(.WIDTH(LANE65_W), .DLY(PASS_DLY)) u_s65 (
        .clk(clk), .rst_n(rst_n), .din(s65_in), .dout(s65_out));
    prot_pass_pipe #(.WIDTH(LANE129_W), .DLY(PASS_DLY)) u_s129 (
        .clk(clk), .rst_n(rst_n), .din(s129_in), .dout(s129_out));

endmodule

// File: tb/tb_prot_accum_secret.sv
// Self-checking bench for prot_accum_secret: instance a uses PASS_DLY=2, instance b PASS_DLY=0.
module tb_prot_accum_secret;

    typedef struct packed {
        logic         s1;
        logic [1:0]   s2;
        logic [7:0]   s8;
        logic [32:0]  s33;
        logic [63:0]  s64;
        logic [64:0]  s65;
        logic [128:0] s129;
    } lanes_t;

    typedef struct {
        logic [31:0] din;
        logic        byp;
        logic [31:0] exp_byp_out;
        logic [31:0] exp_acc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] acc_in_a, acc_in_b;
    logic        byp;
    lanes_t      lin, lout_a, lout_b;
    logic [31:0] acc_out_a, acc_out_b, byp_out_a, byp_out_b;
    logic        acc_valid_a, acc_valid_b, pass_valid_a, pass_valid_b;
`ifdef PROT_ACCUM_SAT_EN
    logic        sat_a, sat_b;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint unsigned acc_a_m, acc_b_m;
    bit              sat_a_m;
    int              edges_m;
    lanes_t          dly_q[$];

    prot_accum_secret #(.ACC_W(32), .PASS_DLY(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
`ifdef PROT_ACCUM_SAT_EN
        .sat_flag(sat_a),
`endif
        .accum_in(acc_in_a), .accum_out(acc_out_a),
        .accum_bypass(byp), .accum_bypass_out(byp_out_a), .acc_valid(acc_valid_a),
        .s1_in(lin.s1), .s1_out(lout_a.s1), .s2_in(lin.s2), .s2_out(lout_a.s2),
        .s8_in(lin.s8), .s8_out(lout_a.s8), .s33_in(lin.s33), .s33_out(lout_a.s33),
        .s64_in(lin.s64), .s64_out(lout_a.s64), .s65_in(lin.s65), .s65_out(lout_a.s65),
        .s129_in(lin.s129), .s129_out(lout_a.s129), .pass_valid(pass_valid_a));

    prot_accum_secret #(.ACC_W(32), .PASS_DLY(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef PROT_ACCUM_SAT_EN
        .sat_flag(sat_b),
`endif
        .accum_in(acc_in_b), .accum_out(acc_out_b),
        .accum_bypass(byp), .accum_bypass_out(byp_out_b), .acc_valid(acc_valid_b),
        .s1_in(lin.s1), .s1_out(lout_b.s1), .s2_in(lin.s2), .s2_out(lout_b.s2),
        .s8_in(lin.s8), .s8_out(lout_b.s8), .s33_in(lin.s33), .s33_out(lout_b.s33),
        .s64_in(lin.s64), .s64_out(lout_b.s64), .s65_in(lin.s65), .s65_out(lout_b.s65),
        .s129_in(lin.s129), .s129_out(lout_b.s129), .pass_valid(pass_valid_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [301:0] act, input logic [301:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned add_model(input longint unsigned acc,
                                                  input logic [31:0] din, inout bit sat);
        longint unsigned sum;
        sum = acc + 64'(din);
`ifdef PROT_ACCUM_SAT_EN
        if (sum > 64'h0000_0000_FFFF_FFFF) begin
            sum = 64'h0000_0000_FFFF_FFFF;
            sat = 1'b1;
        end
`else
        sum = sum & 64'h0000_0000_FFFF_FFFF;
`endif
        return sum;
    endfunction

    task automatic model_reset();
        acc_a_m = 64'd0;
        acc_b_m = 64'd0;
        sat_a_m = 1'b0;
        edges_m = 0;
        dly_q   = {};
        dly_q.push_back('0);
        dly_q.push_back('0);
    endtask

    task automatic compare_model();
        bit dummy;
        dummy = 1'b0;
        check("acc_a", 302'(acc_out_a), 302'(acc_a_m[31:0]));
        check("acc_b", 302'(acc_out_b), 302'(acc_b_m[31:0]));
        check("acc_valid_a", 302'(acc_valid_a), 302'(edges_m >= 1));
        check("acc_valid_b", 302'(acc_valid_b), 302'(edges_m >= 1));
        check("pass_valid_a", 302'(pass_valid_a), 302'(edges_m >= 2));
        check("pass_valid_b", 302'(pass_valid_b), 302'(edges_m >= 1));
        check("lanes_a", 302'(lout_a), 302'(dly_q[0]));
        check("lanes_b", 302'(lout_b), 302'(lin));
`ifdef PROT_ACCUM_SAT_EN
        check("sat_a", 302'(sat_a), 302'(sat_a_m));
        dummy = sat_a_m;
        void'(add_model(64'd0, 32'd0, dummy));
`endif
    endtask

    // One clock edge: advance the model with the current inputs, then compare.
    task automatic tick();
        bit sat_b_m;
        sat_b_m = 1'b0;
        acc_a_m = add_model(acc_a_m, acc_in_a, sat_a_m);
        acc_b_m = add_model(acc_b_m, acc_in_b, sat_b_m);
        dly_q.push_back(lin);
        void'(dly_q.pop_front());
        edges_m++;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_acc_a", 302'(acc_out_a), 302'd0);
        check("rst_pass_valid_a", 302'(pass_valid_a), 302'd0);
        check("rst_lanes_a", 302'(lout_a), 302'd0);
        check("rst_lanes_b_follow", 302'(lout_b), 302'(lin));
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        acc_in_a = 32'd0;
        acc_in_b = 32'd0;
        byp      = 1'b0;
    endtask

    vec_t        tbl[7];
    logic [319:0] rnd;

    initial begin
        tbl[0] = '{32'd0,  1'b0, 32'd0,  32'd0};
        tbl[1] = '{32'd5,  1'b0, 32'd0,  32'd5};
        tbl[2] = '{32'd10, 1'b0, 32'd5,  32'd15};
        tbl[3] = '{32'd15, 1'b0, 32'd15, 32'd30};
        tbl[4] = '{32'd20, 1'b0, 32'd30, 32'd50};
        tbl[5] = '{32'd25, 1'b1, 32'd25, 32'd75};
        tbl[6] = '{32'd7,  1'b0, 32'd75, 32'd82};

        rst_n    = 1'b1;
        acc_in_a = 32'd0;
        acc_in_b = 32'd0;
        byp      = 1'b0;
        lin      = '0;
        model_reset();

        // Accumulation and bypass table
        lin = 302'h5A;
        do_reset();
        check("acc_valid_after_rst", 302'(acc_valid_a), 302'd0);
        for (int i = 0; i < 7; i++) begin
            acc_in_a = tbl[i].din;
            byp      = tbl[i].byp;
            #1;
            check($sformatf("tbl_byp_out[%0d]", i), 302'(byp_out_a), 302'(tbl[i].exp_byp_out));
            tick();
            check($sformatf("tbl_acc[%0d]", i), 302'(acc_out_a), 302'(tbl[i].exp_acc));
            check($sformatf("tbl_valid[%0d]", i), 302'(acc_valid_a), 302'd1);
        end

        // Wrap / saturate boundary
        byp      = 1'b0;
        acc_in_a = 32'hFFFF_FF9E;
        tick();
        check("pre_wrap", 302'(acc_out_a), 302'h0_FFFF_FFF0);
        acc_in_a = 32'h20;
        tick();
`ifdef PROT_ACCUM_SAT_EN
        check("saturate", 302'(acc_out_a), 302'h0_FFFF_FFFF);
        check("sat_flag", 302'(sat_a), 302'd1);
`else
        check("wrap", 302'(acc_out_a), 302'h10);
`endif

        // Pipeline fill with upper-word boundary bits, then async reset mid-run
        lin      = '0;
        do_reset();
        lin.s129 = {1'b1, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF};
        lin.s65  = {1'b1, 64'h0};
        acc_in_a = 32'd100;
        tick();
        check("fill_edge1_pv", 302'(pass_valid_a), 302'd0);
        check("fill_edge1_s129", 302'(lout_a.s129), 302'd0);
        acc_in_a = 32'd0;
        tick();
        check("fill_edge2_pv", 302'(pass_valid_a), 302'd1);
        check("s129_bit128", 302'(lout_a.s129[128]), 302'd1);
        check("s65_bit64", 302'(lout_a.s65[64]), 302'd1);
        check("s129_full", 302'(lout_a.s129), 302'h1_0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
        check("acc_100", 302'(acc_out_a), 302'd100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_acc", 302'(acc_out_a), 302'd0);
        check("async_pv", 302'(pass_valid_a), 302'd0);
        check("async_s129", 302'(lout_a.s129), 302'd0);
        check("async_lanes_b", 302'(lout_b), 302'(lin));
        model_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        acc_in_a = 32'd5;
        tick();
        check("restart_acc", 302'(acc_out_a), 302'd5);

        // Two independent instances
        do_reset();
        for (int i = 0; i < 3; i++) begin
            acc_in_a = 32'(5 * i);
            acc_in_b = 32'(100 + 5 * i);
            tick();
        end
        check("inst_a_sum", 302'(acc_out_a), 302'd15);
        check("inst_b_sum", 302'(acc_out_b), 302'd315);

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            acc_in_a = (n % 4 == 0) ? $urandom() : $urandom_range(0, 1000);
            acc_in_b = $urandom();
            byp      = 1'($urandom_range(0, 1));
            for (int k = 0; k < 10; k++) begin
                rnd[k*32 +: 32] = $urandom();
            end
            lin = rnd[301:0];
            #1;
            check("rnd_byp_out_a", 302'(byp_out_a), byp ? 302'(acc_in_a) : 302'(acc_a_m[31:0]));
            check("rnd_byp_out_b", 302'(byp_out_b), byp ? 302'(acc_in_b) : 302'(acc_b_m[31:0]));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prot_accum_secret.md
Name: prot_accum_secret

Overview:
- Model-side implementation of the protected "secret" block that the DPI-protection regression instantiates.
- Compiled into the protected library; the unprotected wrapper calls it through DPI.
- Contains a wrapping (optionally saturating) 32-bit accumulator with a combinational bypass, plus delayed pass-through lanes of widths 1/2/8/33/64/65/129.
- Exercises the protect-lib marshalling for every word-boundary width class.

Parameters:
- ACC_W, 32: accumulator and accum_in/accum_out width.
- PASS_DLY, 1: pass-through latency in clk cycles, legal 0..4; 0 means combinational pass-through.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- accum_in  input  ACC_W  addend sampled every posedge.
- accum_out  output  ACC_W  registered accumulator value.
- accum_bypass  input  1  selects accum_in onto accum_bypass_out.
- accum_bypass_out  output  ACC_W  accum_bypass ? accum_in : accum_out (combinational).
- acc_valid  output  1  high once the accumulator has taken its first sample after reset.
- s1_in/s1_out  in/out  1  pass-through lane.
- s2_in/s2_out  in/out  2  pass-through lane.
- s8_in/s8_out  in/out  8  pass-through lane.
- s33_in/s33_out  in/out  33  pass-through lane.
- s64_in/s64_out  in/out  64  pass-through lane.
- s65_in/s65_out  in/out  65  pass-through lane.
- s129_in/s129_out  in/out  129  pass-through lane.
- pass_valid  output  1  high once the pass-through pipeline is filled (PASS_DLY samples taken since reset).

Behaviour:
- Reset (rst_n low, asynchronous):
  - accum_out = 0, acc_valid = 0, pass_valid = 0.
  - All pipeline stages and all sN_out = 0 (when PASS_DLY = 0, sN_out follow sN_in even during reset).
  - Fill counter = 0.
- Accumulator: each posedge with rst_n high, accum_out <= accum_out + accum_in, modulo 2^ACC_W (wraps; no carry out).
  - Latency: accum_in at edge N is visible in accum_out after edge N.
  - acc_valid rises after the first such edge and stays high until reset.
- Bypass: purely combinational mux; toggling accum_bypass never alters accumulator state.
  - accum_bypass X/unknown is treated as 0 (the model must not propagate X into the accumulator).
- Pass-through pipeline: each lane is a PASS_DLY-deep shift register, so sN_out(t) = sN_in(t - PASS_DLY).
  - Full-width copy; no truncation or sign extension.
  - Bit 128 of s129 and bit 64 of s65 must survive (these are the upper-word boundary checks).
- Fill FSM: states FILL and RUN.
  - FILL: a 3-bit counter increments each edge; go to RUN when count == PASS_DLY-1 at the edge.
  - RUN: pass_valid = 1, stays in RUN until reset.
  - PASS_DLY = 0: the FSM powers straight into RUN after reset, and pass_valid = 1 on the first edge.
- Reset mid-operation: all state clears immediately; the next sample after release starts from accum_out = 0 in state FILL.
- Simultaneous events: accumulation and pass-through shift occur on the same edge regardless of accum_bypass.
- Elaboration check: PASS_DLY > 4 is a fatal error.

Optional Feature:
- Macro: PROT_ACCUM_SAT_EN
- Defined: the accumulator saturates at 2^ACC_W-1 instead of wrapping.
  - The sticky output sat_flag (1 bit, added port) sets on the first saturating edge and clears only on reset.
- Undefined: modulo wrap, and no sat_flag port.

Decomposition:
- Package prot_accum_pkg holds:
  - the ACC_W default;
  - localparams for the lane widths (1, 2, 8, 33, 64, 65, 129);
  - fill-FSM enum fill_state_t {FILL, RUN};
  - the MAX_PASS_DLY = 4 constant.
- One sub-module, prot_pass_pipe: parameterised by WIDTH and DLY, instantiated once per lane (7 instances). It holds the generate-based delay line, with DLY = 0 as a wire.

Test Plan:
- Reset then accum_in = 0,5,10,15 on successive edges -> accum_out = 0,5,15,30; acc_valid high from the first edge.
- accum_bypass = 1 at cycle 5 with accum_in = 25 -> accum_bypass_out = 25 the same cycle, while accum_out still accumulates (30+20 = 50 previously, then +25 = 75).
- accum_out = 0xFFFF_FFF0, accum_in = 0x20 -> accum_out = 0x10 (wrap). With PROT_ACCUM_SAT_EN -> 0xFFFF_FFFF and sat_flag = 1.
- PASS_DLY = 2, drive s129_in = {1'b1, 128'h0123...CDEF} and s65_in = {1'b1, 64'h0}:
  - pass_valid rises after edge 2;
  - sN_out equal the inputs two cycles later, with bit 128 and bit 64 intact.
- Assert rst_n low mid-run (accum_out = 100) between edges -> accum_out, sN_out and pass_valid drop to 0 immediately without waiting for an edge; accumulation restarts from 0.
- Two instances (as in the generate loop) with accum_in seeded 0 and 100 -> independent sums 0,5,15 and 100,205,315, with no state sharing in the DPI model.
